// File: rtl/clock_set_ctrl.sv
// Time-of-day clock with a three-button set mode: RUN counts seconds, SET_x edits
// one field while the timebase keeps running; an idle timeout falls back to RUN.
module clock_set_ctrl #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TIMEOUT_S = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode_evt,
    input  logic [1:0] up_evt,
    input  logic [1:0] down_evt,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] mode,
    output logic [2:0] blank
);

    localparam int PW = $clog2(CLK_HZ);
    localparam int IW = $clog2(TIMEOUT_S + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2 - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT_S - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } state_t;

    function automatic logic [4:0] step_hours(input logic [4:0] v, input logic inc);
        logic [4:0] res;
        if (inc) begin
            res = (v == 5'd23) ? 5'd0 : v + 5'd1;
        end else begin
            res = (v == 5'd0) ? 5'd23 : v - 5'd1;
        end
        return res;
    endfunction

    function automatic logic [5:0] step_sixty(input logic [5:0] v, input logic inc);
        logic [5:0] res;
        if (inc) begin
            res = (v == 6'd59) ? 6'd0 : v + 6'd1;
        end else begin
            res = (v == 6'd0) ? 6'd59 : v - 6'd1;
        end
        return res;
    endfunction

    state_t        r_state, w_state_next;
    logic [PW-1:0] r_presc, w_presc_next;
    logic          r_blink, w_blink_next;
    logic [IW-1:0] r_idle,  w_idle_next;
    logic [4:0]    r_hours, w_hours_next;
    logic [5:0]    r_mins,  w_mins_next;
    logic [5:0]    r_secs,  w_secs_next;
    logic [2:0]    r_blank, w_blank_next;

    logic w_mode_short, w_mode_long, w_up, w_dn, w_any_evt;
    logic w_sec_tick, w_edit, w_timeout, w_advance;

    // Event decode: code 3 is deliberately treated like "no event".
    assign w_mode_short = (mode_evt == 2'd1);
    assign w_mode_long  = (mode_evt == 2'd2);
    assign w_up         = (up_evt == 2'd1) || (up_evt == 2'd2);
    assign w_dn         = (down_evt == 2'd1) || (down_evt == 2'd2);
    assign w_any_evt    = w_mode_short | w_mode_long | w_up | w_dn;
    assign w_sec_tick   = (r_presc == PRESC_LAST);
    assign w_edit       = (r_state != RUN) && !w_mode_short && !w_mode_long && (w_up ^ w_dn);
    assign w_timeout    = (r_state != RUN) && w_sec_tick && !w_any_evt && (r_idle == IDLE_LAST);
    assign w_advance    = (r_state == RUN) && w_sec_tick && !w_mode_short;

    // Mode transitions: explicit mode events outrank the idle timeout.
    always_comb begin
        w_state_next = r_state;
        if (w_mode_short) begin
            case (r_state)
                RUN:      w_state_next = SET_HOUR;
                SET_HOUR: w_state_next = SET_MIN;
                SET_MIN:  w_state_next = SET_SEC;
                SET_SEC:  w_state_next = RUN;
                default:  w_state_next = RUN;
            endcase
        end else if (w_mode_long || w_timeout) begin
            w_state_next = RUN;
        end else begin
            w_state_next = r_state;
        end
    end

    // Timebase, time-of-day counting and field edits.
    always_comb begin
        w_presc_next = w_sec_tick ? {PW{1'b0}} : r_presc + PW'(1);
        w_blink_next = r_blink ^ (w_sec_tick | (r_presc == PRESC_HALF));
        w_hours_next = r_hours;
        w_mins_next  = r_mins;
        w_secs_next  = r_secs;
        if (w_advance) begin
            w_secs_next = step_sixty(r_secs, 1'b1);
            if (r_secs == 6'd59) begin
                w_mins_next = step_sixty(r_mins, 1'b1);
                if (r_mins == 6'd59) begin
                    w_hours_next = step_hours(r_hours, 1'b1);
                end else begin
                    w_hours_next = r_hours;
                end
            end else begin
                w_mins_next = r_mins;
            end
        end else if (w_edit) begin
            case (r_state)
                SET_HOUR: w_hours_next = step_hours(r_hours, w_up);
                SET_MIN:  w_mins_next  = step_sixty(r_mins, w_up);
                SET_SEC: begin
                    w_secs_next  = 6'd0;
                    w_presc_next = {PW{1'b0}};
                end
                default:  w_secs_next = r_secs;
            endcase
        end else begin
            w_secs_next = r_secs;
        end
    end

    // Idle counter and blank enables follow the upcoming mode.
    always_comb begin
        if ((w_state_next == RUN) || w_any_evt) begin
            w_idle_next = {IW{1'b0}};
        end else if (w_sec_tick) begin
            w_idle_next = r_idle + IW'(1);
        end else begin
            w_idle_next = r_idle;
        end
        case (w_state_next)
            SET_HOUR: w_blank_next = {w_blink_next, 2'b00};
            SET_MIN:  w_blank_next = {1'b0, w_blink_next, 1'b0};
            SET_SEC:  w_blank_next = {2'b00, w_blink_next};
            default:  w_blank_next = 3'b000;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
            r_presc <= {PW{1'b0}};
            r_blink <= 1'b0;
            r_idle  <= {IW{1'b0}};
            r_hours <= 5'd0;
            r_mins  <= 6'd0;
            r_secs  <= 6'd0;
            r_blank <= 3'b000;
        end else begin
            r_state <= w_state_next;
            r_presc <= w_presc_next;
            r_blink <= w_blink_next;
            r_idle  <= w_idle_next;
            r_hours <= w_hours_next;
            r_mins  <= w_mins_next;
            r_secs  <= w_secs_next;
            r_blank <= w_blank_next;
        end
    end

    assign hours   = r_hours;
    assign minutes = r_mins;
    assign seconds = r_secs;
    assign mode    = r_state;
    assign blank   = r_blank;

endmodule
